countdown_timer: RTL and testbench
==================================

# countdown_timer

Four-digit BCD mm:ss countdown timer built as a chain of down-counting digits with borrow propagation. It is the decrementing counterpart of the up-counter digit chain. It sits between the 1 Hz tick prescaler and the seven-segment display scanner, and is controlled by debounced one-pulse start/pause and load buttons. An internal FSM gates counting and flags expiry.

## Interface
Parameters:
- SEC_ONES_LIMIT, 4'd9: wrap value of seconds-ones digit on borrow
- SEC_TENS_LIMIT, 4'd5: wrap value of seconds-tens digit
- MIN_ONES_LIMIT, 4'd9: wrap value of minutes-ones digit
- MIN_TENS_LIMIT, 4'd5: wrap value of minutes-tens digit

Ports:
- clk  input  1  global clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- decrease  input  1  count enable; one-cycle tick pulse from prescaler
- start_pause  input  1  one-cycle pulse; start/pause toggle
- load  input  1  one-cycle pulse; reload initial value
- value_initial  input  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD
- value  output  16  current digits, same packing
- state  output  2  FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
- done  output  1  high while state == DONE
- expired  output  1  one-cycle registered pulse on reaching 0000

## Operation
- Clamped init: each digit of value_initial greater than its LIMIT is replaced by that LIMIT wherever init is used (reset, load, autoreload).
- Decrement (RUN and decrease=1 only):
  - sec_ones decrements.
  - A digit at 0 wraps to its LIMIT and borrows into the next digit.
  - A digit receiving a borrow decrements under the same rule.
- FSM:
  - IDLE: start_pause → RUN if clamped value != 0000; → DONE if value == 0000, with expired pulsed.
  - RUN: start_pause → PAUSE; otherwise decrement on decrease. The decrement that produces 0000 → DONE, with expired pulsed.
  - PAUSE: start_pause → RUN; decrease ignored; value held.
  - DONE: value held at 0000; start_pause and decrease ignored.
  - Any state: load → IDLE, value ← clamped init.
- Priority within one cycle: load > start_pause > decrease.
  - start_pause in RUN together with decrease: pause wins; no decrement that cycle.
  - start_pause in PAUSE together with decrease: resume only; first decrement on a later tick.
- Outputs `done` and `state` decode the state register directly.

## Timing
- Reset (rst_n low, asynchronous): value = clamped value_initial, state = IDLE, done = 0, expired = 0. Release takes effect on the next posedge.
- All updates are registered, with one-edge latency: an input sampled high at edge N is reflected in outputs after edge N.
- Borrow ripples combinationally through all four digits in one cycle. Example: 10:00 → 09:59 in a single edge.
- expired is high for exactly one cycle: the cycle following the edge that entered DONE (or reloaded, see below). It is 0 otherwise.
- value_initial is sampled only at reset, on load, and on autoreload. It must be stable around those edges.
- Back-to-back decrease pulses on consecutive cycles are legal and each counts.

## Configuration
- COUNTDOWN_AUTORELOAD_EN defined:
  - The RUN decrement that reaches 0000 instead reloads clamped value_initial and stays in RUN. expired still pulses one cycle.
  - DONE is reachable only from IDLE with a zero init.
- COUNTDOWN_AUTORELOAD_EN undefined: behaviour exactly as in Operation (RUN → DONE, hold at 0000).

## Test plan
- Reset with init 16'h0105, start, 5 ticks → value 0105→0104→…→0100; state RUN, done 0.
- Init 16'h1000, start, 1 tick → value 16'h0959 after one edge (full borrow chain).
- Init 16'h0002, start, 2 ticks → 0000, state DONE, done 1, expired high one cycle. Further ticks and start_pause leave 0000/DONE. With COUNTDOWN_AUTORELOAD_EN: value 0002, state RUN, expired one cycle.
- In RUN at 0030, start_pause together with decrease → PAUSE, value 0030. Three ticks → still 0030. start_pause → RUN, next tick → 0029.
- Init 16'h7A9F (out of range) → after reset value 16'h5959. load mid-RUN together with start_pause and decrease → IDLE, value 5959.
- Init 0000, start → DONE with expired pulse. Assert rst_n low mid-count at 0042 → immediately value = init, state IDLE, done 0.

Source files
------------

// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer.
// master: the controller side (prescaler tick, buttons, initial value) which
//         drives the requests and observes the digits and status.
// slave:  the countdown_timer itself.
interface countdown_timer_if;
    logic        decrease;
    logic        start_pause;
    logic        load;
    logic [15:0] value_initial;
    logic [15:0] value;
    logic [1:0]  state;
    logic        done;
    logic        expired;

    modport master (
        output decrease,
        output start_pause,
        output load,
        output value_initial,
        input  value,
        input  state,
        input  done,
        input  expired
    );

    modport slave (
        input  decrease,
        input  start_pause,
        input  load,
        input  value_initial,
        output value,
        output state,
        output done,
        output expired
    );
endinterface

// File: rtl/countdown_timer.sv
// Four-digit BCD mm:ss countdown timer: down-counting digit chain with a
// combinational borrow ripple, gated by an IDLE/RUN/PAUSE/DONE FSM.
// Optional feature macro: COUNTDOWN_AUTORELOAD_EN -- when defined, reaching
// 0000 while running reloads the clamped initial value and keeps running
// instead of stopping in DONE.
module countdown_timer #(
    parameter logic [3:0] SEC_ONES_LIMIT = 4'd9,
    parameter logic [3:0] SEC_TENS_LIMIT = 4'd5,
    parameter logic [3:0] MIN_ONES_LIMIT = 4'd9,
    parameter logic [3:0] MIN_TENS_LIMIT = 4'd5
) (
    input  logic               clk,
    input  logic               rst_n,
    countdown_timer_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Digit limits packed like the value: {min_tens, min_ones, sec_tens, sec_ones}
    localparam logic [15:0] LIMITS = {MIN_TENS_LIMIT, MIN_ONES_LIMIT,
                                      SEC_TENS_LIMIT, SEC_ONES_LIMIT};

    state_t      state_reg;
    logic [15:0] value_reg;
    logic        expired_reg;

    logic [15:0] init_clamped;
    logic [15:0] value_dec;
    logic [3:0]  borrow;

    // sec_ones always receives the decrement request
    assign borrow[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIM = LIMITS[gi*4 +: 4];
            logic [3:0] init_digit;
            logic [3:0] cur_digit;

            assign init_digit = bus.value_initial[gi*4 +: 4];
            assign cur_digit  = value_reg[gi*4 +: 4];

            // Out-of-range initial digits saturate at their limit
            assign init_clamped[gi*4 +: 4] = (init_digit > LIM) ? LIM : init_digit;

            // A borrowed-into digit at zero wraps to its limit, else steps down
            assign value_dec[gi*4 +: 4] = !borrow[gi]        ? cur_digit :
                                          (cur_digit == 4'd0) ? LIM       :
                                                                cur_digit - 4'd1;

            // Borrow passes on only through digits that were at zero
            if (gi < 3) begin : g_borrow
                assign borrow[gi+1] = borrow[gi] & (cur_digit == 4'd0);
            end
        end
    endgenerate

    // Control FSM and digit register; priority is load > start_pause > decrease
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            value_reg   <= init_clamped;
            expired_reg <= 1'b0;
        end else begin
            expired_reg <= 1'b0;
            if (bus.load) begin
                state_reg <= IDLE;
                value_reg <= init_clamped;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (bus.start_pause) begin
                            if (value_reg != 16'h0000) begin
                                state_reg <= RUN;
                            end else begin
                                state_reg   <= DONE;
                                expired_reg <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (bus.start_pause) begin
                            state_reg <= PAUSE;
                        end else if (bus.decrease) begin
                            if (value_dec == 16'h0000) begin
                                expired_reg <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                                value_reg   <= init_clamped;
`else
                                value_reg   <= 16'h0000;
                                state_reg   <= DONE;
`endif
                            end else begin
                                value_reg <= value_dec;
                            end
                        end
                    end
                    PAUSE: begin
                        if (bus.start_pause) begin
                            state_reg <= RUN;
                        end
                    end
                    default: begin
                        // DONE holds until a load
                        state_reg <= DONE;
                    end
                endcase
            end
        end
    end

    assign bus.value   = value_reg;
    assign bus.state   = state_reg;
    assign bus.done    = (state_reg == DONE);
    assign bus.expired = expired_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios followed by a
// randomized phase, all checked against a total-seconds reference model.
module tb_countdown_timer;

    logic clk;
    logic rst_n;

    countdown_timer_if bus ();

    countdown_timer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: remaining time in plain seconds plus a state number
    int          m_secs;
    int          m_state;   // 0 IDLE, 1 RUN, 2 PAUSE, 3 DONE
    bit          m_exp;
    logic [15:0] cur_init;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // Clamped init expressed as total seconds
    function automatic int init_secs(input logic [15:0] v);
        int mt, mo, st, so;
        mt = min_int(int'(v[15:12]), 5);
        mo = min_int(int'(v[11:8]), 9);
        st = min_int(int'(v[7:4]), 5);
        so = min_int(int'(v[3:0]), 9);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    function automatic void model_edge(input bit ld, input bit sp, input bit dec);
        m_exp = 1'b0;
        if (ld) begin
            m_state = 0;
            m_secs  = init_secs(cur_init);
        end else begin
            case (m_state)
                0: if (sp) begin
                       if (m_secs != 0) m_state = 1;
                       else begin m_state = 3; m_exp = 1'b1; end
                   end
                1: if (sp) m_state = 2;
                   else if (dec) begin
                       m_secs = m_secs - 1;
                       if (m_secs == 0) begin
                           m_exp = 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
                           m_secs = init_secs(cur_init);
`else
                           m_state = 3;
`endif
                       end
                   end
                2: if (sp) m_state = 1;
                default: ;
            endcase
        end
    endfunction

    task automatic compare_all(input string tag);
        check({tag, ".value"},   bus.value,   to_bcd(m_secs));
        check({tag, ".state"},   {14'd0, bus.state},   16'(m_state));
        check({tag, ".done"},    {15'd0, bus.done},    {15'd0, m_state == 3});
        check({tag, ".expired"}, {15'd0, bus.expired}, {15'd0, m_exp});
    endtask

    // One clock: drive at negedge, advance model at posedge, sample 1 ns later
    task automatic cycle(input bit ld, input bit sp, input bit dec, input string tag);
        @(negedge clk);
        bus.load          = ld;
        bus.start_pause   = sp;
        bus.decrease      = dec;
        bus.value_initial = cur_init;
        @(posedge clk);
        model_edge(ld, sp, dec);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset asserted between edges, checked before the next edge
    task automatic do_reset(input logic [15:0] init, input string tag);
        @(negedge clk);
        bus.load = 1'b0; bus.start_pause = 1'b0; bus.decrease = 1'b0;
        cur_init = init;
        bus.value_initial = init;
        #2;
        rst_n = 1'b0;
        #1;
        m_state = 0; m_secs = init_secs(init); m_exp = 1'b0;
        compare_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load_init(input logic [15:0] init, input string tag);
        cur_init = init;
        cycle(1, 0, 0, tag);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.load = 1'b0; bus.start_pause = 1'b0; bus.decrease = 1'b0;
        cur_init = 16'h0105;
        bus.value_initial = cur_init;
        m_state = 0; m_secs = 0; m_exp = 1'b0;

        // 01:05 counts down to 01:00
        do_reset(16'h0105, "rst0105");
        cycle(0, 1, 0, "start0105");
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, "tick0105");
        check("v0100", bus.value, 16'h0100);
        check("run0100", {14'd0, bus.state}, 16'd1);

        // Full borrow ripple 10:00 -> 09:59
        load_init(16'h1000, "ld1000");
        cycle(0, 1, 0, "start1000");
        cycle(0, 0, 1, "tick1000");
        check("v0959", bus.value, 16'h0959);

        // Expiry from 00:02
        load_init(16'h0002, "ld0002");
        cycle(0, 1, 0, "start0002");
        cycle(0, 0, 1, "tick0002a");
        cycle(0, 0, 1, "tick0002b");
`ifdef COUNTDOWN_AUTORELOAD_EN
        check("reload0002", bus.value, 16'h0002);
        check("reloadrun", {14'd0, bus.state}, 16'd1);
`else
        check("v0000", bus.value, 16'h0000);
        check("done0000", {15'd0, bus.done}, 16'd1);
`endif
        check("exp0000", {15'd0, bus.expired}, 16'd1);
        cycle(0, 0, 0, "expdrop");
        check("exp1cyc", {15'd0, bus.expired}, 16'd0);
        cycle(0, 0, 1, "donetick");
        cycle(0, 1, 0, "donesp");
        cycle(0, 1, 1, "donespdec");

        // Pause wins over a simultaneous tick; resume does not decrement
        load_init(16'h0030, "ld0030");
        cycle(0, 1, 0, "start0030");
        cycle(0, 1, 1, "pausedec");
        check("pause", {14'd0, bus.state}, 16'd2);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, "pausedtick");
        check("held0030", bus.value, 16'h0030);
        cycle(0, 1, 1, "resumedec");
        check("resumeheld", bus.value, 16'h0030);
        cycle(0, 0, 1, "tick0029");
        check("v0029", bus.value, 16'h0029);

        // Clamping and load priority
        do_reset(16'h7A9F, "rst7a9f");
        check("clamp5959", bus.value, 16'h5959);
        cycle(0, 1, 0, "start5959");
        cycle(0, 0, 1, "tick5959");
        check("v5958", bus.value, 16'h5958);
        cycle(1, 1, 1, "ldprio");
        check("ldprio_v", bus.value, 16'h5959);
        check("ldprio_s", {14'd0, bus.state}, 16'd0);

        // Zero init goes straight to DONE
        load_init(16'h0000, "ld0000");
        cycle(0, 1, 0, "start0000");
        check("zero_done", {14'd0, bus.state}, 16'd3);
        check("zero_exp", {15'd0, bus.expired}, 16'd1);

        // Asynchronous reset mid-count
        load_init(16'h0045, "ld0045");
        cycle(0, 1, 0, "start0045");
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, "tick0045");
        check("v0042", bus.value, 16'h0042);
        do_reset(16'h0045, "midrst");

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            bit ld, sp, dec;
            ld  = ($urandom % 40) == 0;
            sp  = ($urandom % 8) == 0;
            dec = ($urandom % 2) == 0;
            if (ld) begin
                if ($urandom % 2) cur_init = {8'h00, 8'($urandom)};
                else              cur_init = 16'($urandom);
            end
            cycle(ld, sp, dec, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
